// File: rtl/wgt_tile_addr_gen.sv
// wgt_tile_addr_gen
//   Weight-address generator for the systolic array. A layer config is
//   latched on `start`; each `load` then streams one filter tile of
//   weight addresses (k*k*C beats) to the weight RAM under valid/ready
//   handshaking. The block tracks the remaining filters itself, sizes the
//   last partial tile, and pulses tile/layer completion.
//
//   Optional feature: define WGT_ADDR_BOUND_CHECK_EN to build a sticky
//   bound check (addr_err) on accepted beats. Without it addr_err is tied 0.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                latch layer config (IDLE only)
//   load                 request next tile (IDLE, filters remaining)
//   layer_base_addr      first weight word of the layer
//   kernel_size          1..7
//   num_channel          channel count
//   num_filter           filter count
//   rd_ready             downstream accepts current beat
//   wgt_addr             current beat address
//   read_en              beat valid
//   read_wgt_size        filters in the current tile
//   tile_done            pulse after a tile's last beat is accepted
//   layer_done           pulse when the final tile completes
//   busy                 not IDLE
//   cfg_err              sticky: last start carried a zero field
//   addr_err             sticky bound violation (optional feature)
module wgt_tile_addr_gen #(
   parameter int SYSTOLIC_SIZE = 16,
   parameter int WGT_RAM_SIZE  = 8845488,
   parameter int ADDR_W        = $clog2(WGT_RAM_SIZE),
   parameter int CH_W          = 11,
   parameter int FLT_W         = 11,
   parameter int CNT_W         = CH_W + 6
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               load,
   input  logic [ADDR_W-1:0]                  layer_base_addr,
   input  logic [2:0]                         kernel_size,
   input  logic [CH_W-1:0]                    num_channel,
   input  logic [FLT_W-1:0]                   num_filter,
   input  logic                               rd_ready,
   output logic [ADDR_W-1:0]                  wgt_addr,
   output logic                               read_en,
   output logic [$clog2(SYSTOLIC_SIZE):0]     read_wgt_size,
   output logic                               tile_done,
   output logic                               layer_done,
   output logic                               busy,
   output logic                               cfg_err,
   output logic                               addr_err
);

   localparam int SZ_W = $clog2(SYSTOLIC_SIZE) + 1;

   typedef enum logic [1:0] {IDLE, SETUP, ADDRESSING, UPDATE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  wpf;
   logic [CNT_W-1:0]  cnt;
   logic [FLT_W-1:0]  rem_filt;
   logic              accept;
   logic              last_beat;
   logic              cfg_zero;

   assign accept    = read_en & rd_ready;
   assign last_beat = (cnt == wpf - CNT_W'(1));
   assign cfg_zero  = (kernel_size == 3'd0) || (num_channel == '0) || (num_filter == '0);

   assign read_en    = (state == ADDRESSING);
   assign busy       = (state != IDLE);
   assign tile_done  = (state == UPDATE);
   // rem_filt is decremented at the end of UPDATE, so the final tile is the
   // one whose size equals what is still outstanding.
   assign layer_done = (state == UPDATE) && (rem_filt == FLT_W'(read_wgt_size));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (!start && load && rem_filt != '0) state_nxt = SETUP;
         SETUP:      state_nxt = ADDRESSING;
         ADDRESSING: if (accept && last_beat) state_nxt = UPDATE;
         UPDATE:     state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wgt_addr      <= '0;
         wpf           <= '0;
         cnt           <= '0;
         rem_filt      <= '0;
         read_wgt_size <= SZ_W'(SYSTOLIC_SIZE);
         cfg_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  wpf      <= CNT_W'(kernel_size) * CNT_W'(kernel_size) * CNT_W'(num_channel);
                  rem_filt <= cfg_zero ? '0 : num_filter;
                  wgt_addr <= layer_base_addr;
                  cfg_err  <= cfg_zero;
               end
            end
            SETUP: begin
               read_wgt_size <= (rem_filt >= FLT_W'(SYSTOLIC_SIZE)) ? SZ_W'(SYSTOLIC_SIZE)
                                                                    : SZ_W'(rem_filt);
               cnt           <= '0;
            end
            ADDRESSING: begin
               if (accept) begin
                  // addresses advance by tile width and wrap modulo 2^ADDR_W
                  wgt_addr <= wgt_addr + ADDR_W'(read_wgt_size);
                  cnt      <= cnt + CNT_W'(1);
               end
            end
            UPDATE: rem_filt <= rem_filt - FLT_W'(read_wgt_size);
            default: ;
         endcase
      end
   end

`ifdef WGT_ADDR_BOUND_CHECK_EN
   logic [ADDR_W:0] beat_end;
   assign beat_end = {1'b0, wgt_addr} + (ADDR_W+1)'(read_wgt_size);

   always_ff @(posedge clk) begin
      if (rst)
         addr_err <= 1'b0;
      else if (state == IDLE && start)
         addr_err <= 1'b0;
      else if (accept && beat_end > (ADDR_W+1)'(WGT_RAM_SIZE))
         addr_err <= 1'b1;
   end
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_wgt_tile_addr_gen.sv
module tb_wgt_tile_addr_gen;

   localparam int SYS    = 16;
   localparam int RAMSZ  = 8845488;
   localparam int ADDR_W = 24;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [4:0]        size;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              load = 1'b0;
   logic [ADDR_W-1:0] layer_base_addr = '0;
   logic [2:0]        kernel_size = '0;
   logic [10:0]       num_channel = '0;
   logic [10:0]       num_filter = '0;
   logic              rd_ready = 1'b1;
   logic [ADDR_W-1:0] wgt_addr;
   logic              read_en;
   logic [4:0]        read_wgt_size;
   logic              tile_done, layer_done, busy, cfg_err, addr_err;

   int n_vec = 0;
   int n_err = 0;

   beat_t beat_q[$];
   logic  tile_q[$];

   // reference model state
   int unsigned m_addr, m_rem, m_wpf;

   wgt_tile_addr_gen #(.SYSTOLIC_SIZE(SYS), .WGT_RAM_SIZE(RAMSZ), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .load(load),
      .layer_base_addr(layer_base_addr), .kernel_size(kernel_size),
      .num_channel(num_channel), .num_filter(num_filter), .rd_ready(rd_ready),
      .wgt_addr(wgt_addr), .read_en(read_en), .read_wgt_size(read_wgt_size),
      .tile_done(tile_done), .layer_done(layer_done), .busy(busy),
      .cfg_err(cfg_err), .addr_err(addr_err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (read_en && rd_ready) begin
            if (beat_q.size() == 0) chk("unexpected_beat", wgt_addr, -1);
            else begin
               beat_t b;
               b = beat_q.pop_front();
               chk("beat_addr", wgt_addr, b.addr);
               chk("beat_size", read_wgt_size, b.size);
            end
         end
         if (tile_done) begin
            if (tile_q.size() == 0) chk("unexpected_tile_done", 1, 0);
            else chk("layer_done", layer_done, tile_q.pop_front());
         end else if (layer_done) chk("layer_done_without_tile", 1, 0);
      end
   end

   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   // all tasks are entered and left at posedge+1
   task automatic do_start(input int unsigned base, input int k, input int c, input int f,
                           input bit with_load);
      layer_base_addr = ADDR_W'(base);
      kernel_size = 3'(k); num_channel = 11'(c); num_filter = 11'(f);
      start = 1'b1; load = with_load;
      m_addr = base; m_wpf = k * k * c;
      m_rem  = (k == 0 || c == 0 || f == 0) ? 0 : f;
      @(posedge clk); #1;
      start = 1'b0; load = 1'b0;
   endtask

   task automatic push_tile();
      int unsigned sz;
      beat_t b;
      if (m_rem == 0) return;
      sz = min_u(m_rem, SYS);
      for (int i = 0; i < int'(m_wpf); i++) begin
         b.addr = ADDR_W'(m_addr); b.size = 5'(sz);
         beat_q.push_back(b);
         m_addr = m_addr + sz;
      end
      m_rem = m_rem - sz;
      tile_q.push_back(m_rem == 0);
   endtask

   task automatic do_load();
      push_tile();
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!busy) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk(name, ok, 1);
   endtask

   task automatic wait_addr(input int unsigned a, input string name);
      bit ok = 0;
      for (int i = 0; i < 500; i++) begin
         if (read_en && wgt_addr == ADDR_W'(a)) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk(name, ok, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"}, wgt_addr, 0);
      chk({tag, "_read_en"}, read_en, 0);
      chk({tag, "_size"}, read_wgt_size, SYS);
      chk({tag, "_tile_done"}, tile_done, 0);
      chk({tag, "_layer_done"}, layer_done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
      chk({tag, "_addr_err"}, addr_err, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // basic two-tile layer
      do_start(100, 3, 4, 20, 0);
      chk("start_busy", busy, 0);
      chk("start_addr", wgt_addr, 100);
      do_load();
      chk("setup_read_en", read_en, 0);
      chk("setup_busy", busy, 1);
      @(posedge clk); #1;
      chk("latency_read_en", read_en, 1);
      chk("first_addr", wgt_addr, 100);
      wait_idle("tile0_idle");
      chk("tile0_next_addr", wgt_addr, 676);
      do_load();
      wait_idle("tile1_idle");
      chk("tile1_next_addr", wgt_addr, 820);
      do_load();                         // nothing remains: ignored
      chk("third_load_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;

      // backpressure at beat 5
      do_start(100, 3, 4, 20, 0);
      do_load();
      wait_addr(180, "reach_180");
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_addr", wgt_addr, 180);
         chk("stall_read_en", read_en, 1);
      end
      @(posedge clk); #1;
      rd_ready = 1'b1;
      wait_idle("bp_idle");
      chk("bp_next_addr", wgt_addr, 676);

      // start + load together: only the config is taken
      do_start(100, 3, 4, 20, 1);
      chk("start_load_busy", busy, 0);
      @(posedge clk); #1;
      chk("start_load_busy2", busy, 0);
      do_load();
      wait_idle("sl_tile0_idle");
      chk("sl_next_addr", wgt_addr, 676);

      // reset mid-tile at beat 10
      do_start(100, 3, 4, 20, 0);
      m_wpf = 10;                        // only beats 0..9 get accepted
      push_tile();
      void'(tile_q.pop_back());          // aborted tile never completes
      m_wpf = 36;
      load = 1'b1; @(posedge clk); #1; load = 1'b0;
      wait_addr(260, "reach_260");
      rst = 1'b1; rd_ready = 1'b0;
      @(posedge clk); #1;
      chk_reset_vals("midreset");
      @(posedge clk); #1;
      chk("midreset_tile_done", tile_done, 0);
      rst = 1'b0; rd_ready = 1'b1;
      chk("midreset_beats_drained", beat_q.size(), 0);
      do_start(100, 3, 4, 20, 0);
      do_load();
      wait_idle("replay_idle");
      chk("replay_next_addr", wgt_addr, 676);

      // zero channel count
      do_start(100, 3, 0, 20, 0);
      chk("cfg_err_set", cfg_err, 1);
      do_load();
      chk("cfg_err_busy", busy, 0);
      @(posedge clk); #1;
      chk("cfg_err_busy2", busy, 0);
      do_start(100, 3, 4, 20, 0);
      chk("cfg_err_clr", cfg_err, 0);

      // bound check near top of RAM
      do_start(RAMSZ - 8, 1, 1, 16, 0);
      do_load();
      wait_idle("bound_idle");
`ifdef WGT_ADDR_BOUND_CHECK_EN
      chk("addr_err", addr_err, 1);
      do_start(100, 1, 1, 1, 0);
      chk("addr_err_clr", addr_err, 0);
`else
      chk("addr_err", addr_err, 0);
`endif

      repeat (4) @(posedge clk);
      chk("beat_q_empty", beat_q.size(), 0);
      chk("tile_q_empty", tile_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
